pipe_stall_fwd: RTL and testbench

Pipeline register block holding the IF/ID and ID/EX registers of the 5-stage core. It carries out the stall, bubble and operand-forwarding decisions made by the hazard detection unit. It also applies branch flushes and keeps saturating stall/flush performance counters. It sits between fetch, the register-file read in decode, and the EX stage.

---
 rtl/pipe_pkg.sv | 10 +
 rtl/fwd_mux.sv | 17 +
 rtl/pipe_stall_fwd.sv | 128 ++++++++++++
 tb/tb_pipe_stall_fwd.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, NOP encoding and the pipeline control record
package pipe_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
    } ctl_t;
    localparam ctl_t BUBBLE_CTL = '{valid: 1'b0, inst: NOP_INST};
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: priority operand select (alu > mem_alu > mem > rdata) with multi-select detect
module fwd_mux #(
    parameter int W = 32
) (
    input  logic         sel_alu_i,
    input  logic         sel_mem_alu_i,
    input  logic         sel_mem_i,
    input  logic [W-1:0] alu_i,
    input  logic [W-1:0] mem_alu_i,
    input  logic [W-1:0] mem_i,
    input  logic [W-1:0] rdata_i,
    output logic [W-1:0] op_o,
    output logic         multi_o
);
    assign op_o    = sel_alu_i ? alu_i : sel_mem_alu_i ? mem_alu_i : sel_mem_i ? mem_i : rdata_i;
    assign multi_o = (sel_alu_i & (sel_mem_alu_i | sel_mem_i)) | (sel_mem_alu_i & sel_mem_i);
endmodule

// File: rtl/pipe_stall_fwd.sv
// pipe_stall_fwd: IF/ID and ID/EX registers with stall, bubble, flush, forwarding and perf counters
module pipe_stall_fwd
    import pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_if_valid,
    input  logic [XLEN-1:0]  i_if_pc,
    input  logic [31:0]      i_if_inst,
    output logic             o_id_valid,
    output logic [XLEN-1:0]  o_id_pc,
    output logic [31:0]      o_id_inst,
    output logic             o_pc_hold,
    input  logic [XLEN-1:0]  i_rs1_rdata,
    input  logic [XLEN-1:0]  i_rs2_rdata,
    input  logic             i_if_id_halt,
    input  logic             i_id_ex_halt,
    input  logic             i_frwd_alu_op1,
    input  logic             i_frwd_mem_alu_op1,
    input  logic             i_frwd_mem_op1,
    input  logic             i_frwd_alu_op2,
    input  logic             i_frwd_mem_alu_op2,
    input  logic             i_frwd_mem_op2,
    input  logic [XLEN-1:0]  i_ex_alu_res,
    input  logic [XLEN-1:0]  i_mem_alu_res,
    input  logic [XLEN-1:0]  i_mem_rdata,
    input  logic             i_flush,
    output logic             o_ex_valid,
    output logic [XLEN-1:0]  o_ex_pc,
    output logic [31:0]      o_ex_inst,
    output logic [XLEN-1:0]  o_ex_op1,
    output logic [XLEN-1:0]  o_ex_op2,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic             o_fwd_err
);
    ctl_t             id_q, id_d, ex_q, ex_d;
    logic [XLEN-1:0]  id_pc_q, id_pc_d, ex_pc_q, ex_pc_d;
    logic [XLEN-1:0]  op1_q, op1_d, op2_q, op2_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             err_q, err_d, halt_q, halt_d;
    logic [XLEN-1:0]  sel_op1, sel_op2;
    logic             multi1, multi2, kill_ex, any_halt;

    fwd_mux #(.W(XLEN)) u_fwd_op1 (
        .sel_alu_i     (i_frwd_alu_op1),
        .sel_mem_alu_i (i_frwd_mem_alu_op1),
        .sel_mem_i     (i_frwd_mem_op1),
        .alu_i         (i_ex_alu_res),
        .mem_alu_i     (i_mem_alu_res),
        .mem_i         (i_mem_rdata),
        .rdata_i       (i_rs1_rdata),
        .op_o          (sel_op1),
        .multi_o       (multi1)
    );

    fwd_mux #(.W(XLEN)) u_fwd_op2 (
        .sel_alu_i     (i_frwd_alu_op2),
        .sel_mem_alu_i (i_frwd_mem_alu_op2),
        .sel_mem_i     (i_frwd_mem_op2),
        .alu_i         (i_ex_alu_res),
        .mem_alu_i     (i_mem_alu_res),
        .mem_i         (i_mem_rdata),
        .rdata_i       (i_rs2_rdata),
        .op_o          (sel_op2),
        .multi_o       (multi2)
    );

    assign o_pc_hold = i_if_id_halt & ~i_flush;
    assign kill_ex   = i_flush | i_id_ex_halt;
    assign any_halt  = i_if_id_halt | i_id_ex_halt;

    // next state: flush beats halts; halts only count and check when no flush is present
    always_comb begin
        id_d    = i_flush ? BUBBLE_CTL : i_if_id_halt ? id_q : ctl_t'({i_if_valid, i_if_inst});
        id_pc_d = i_flush ? '0 : i_if_id_halt ? id_pc_q : i_if_pc;
        ex_d    = kill_ex ? BUBBLE_CTL : id_q;
        ex_pc_d = kill_ex ? '0 : id_pc_q;
        op1_d   = kill_ex ? '0 : sel_op1;
        op2_d   = kill_ex ? '0 : sel_op2;
        stall_d = (o_pc_hold && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
        flush_d = (i_flush && flush_q != '1) ? flush_q + CNT_W'(1) : flush_q;
        halt_d  = any_halt & ~i_flush;
        err_d   = err_q | (~i_flush & ((i_if_id_halt ^ i_id_ex_halt) | (halt_q & any_halt) | (id_q.valid & (multi1 | multi2))));
    end

    // pipeline, counter and error state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            id_q    <= BUBBLE_CTL;
            id_pc_q <= '0;
            ex_q    <= BUBBLE_CTL;
            ex_pc_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            id_q    <= id_d;
            id_pc_q <= id_pc_d;
            ex_q    <= ex_d;
            ex_pc_q <= ex_pc_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            halt_q  <= halt_d;
            err_q   <= err_d;
        end
    end

    assign o_id_valid  = id_q.valid;
    assign o_id_inst   = id_q.inst;
    assign o_id_pc     = id_pc_q;
    assign o_ex_valid  = ex_q.valid;
    assign o_ex_inst   = ex_q.inst;
    assign o_ex_pc     = ex_pc_q;
    assign o_ex_op1    = op1_q;
    assign o_ex_op2    = op2_q;
    assign o_stall_cnt = stall_q;
    assign o_flush_cnt = flush_q;
    assign o_fwd_err   = err_q;
endmodule

// File: tb/tb_pipe_stall_fwd.sv
// tb_pipe_stall_fwd: directed and randomized checks of pipe_stall_fwd against a behavioural model
module tb_pipe_stall_fwd;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic i_clk = 0, i_rst = 0;
    logic i_if_valid = 0, i_if_id_halt = 0, i_id_ex_halt = 0, i_flush = 0;
    logic [31:0] i_if_pc = 0, i_if_inst = 0, i_rs1_rdata = 0, i_rs2_rdata = 0;
    logic i_frwd_alu_op1 = 0, i_frwd_mem_alu_op1 = 0, i_frwd_mem_op1 = 0;
    logic i_frwd_alu_op2 = 0, i_frwd_mem_alu_op2 = 0, i_frwd_mem_op2 = 0;
    logic [31:0] i_ex_alu_res = 0, i_mem_alu_res = 0, i_mem_rdata = 0;

    logic o_id_valid, o_pc_hold, o_ex_valid, o_fwd_err;
    logic [31:0] o_id_pc, o_id_inst, o_ex_pc, o_ex_inst, o_ex_op1, o_ex_op2, o_stall_cnt, o_flush_cnt;
    logic d4_id_valid, d4_pc_hold, d4_ex_valid, d4_fwd_err;
    logic [31:0] d4_id_pc, d4_id_inst, d4_ex_pc, d4_ex_inst, d4_ex_op1, d4_ex_op2;
    logic [3:0] d4_stall_cnt, d4_flush_cnt;

    int n_chk = 0, n_fail = 0;

    logic        m_id_v, m_ex_v, m_err, m_prev_halt;
    logic [31:0] m_id_pc, m_id_inst, m_ex_pc, m_ex_inst, m_op1, m_op2;
    longint      m_stall, m_flush;
    int          m_stall4, m_flush4;

    always #5 i_clk = ~i_clk;

    pipe_stall_fwd #(.XLEN(32), .CNT_W(32)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_if_valid(i_if_valid), .i_if_pc(i_if_pc), .i_if_inst(i_if_inst),
        .o_id_valid(o_id_valid), .o_id_pc(o_id_pc), .o_id_inst(o_id_inst), .o_pc_hold(o_pc_hold),
        .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata), .i_if_id_halt(i_if_id_halt), .i_id_ex_halt(i_id_ex_halt),
        .i_frwd_alu_op1(i_frwd_alu_op1), .i_frwd_mem_alu_op1(i_frwd_mem_alu_op1), .i_frwd_mem_op1(i_frwd_mem_op1),
        .i_frwd_alu_op2(i_frwd_alu_op2), .i_frwd_mem_alu_op2(i_frwd_mem_alu_op2), .i_frwd_mem_op2(i_frwd_mem_op2),
        .i_ex_alu_res(i_ex_alu_res), .i_mem_alu_res(i_mem_alu_res), .i_mem_rdata(i_mem_rdata), .i_flush(i_flush),
        .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc), .o_ex_inst(o_ex_inst), .o_ex_op1(o_ex_op1), .o_ex_op2(o_ex_op2),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt), .o_fwd_err(o_fwd_err)
    );

    pipe_stall_fwd #(.XLEN(32), .CNT_W(4)) u_dut4 (
        .i_clk(i_clk), .i_rst(i_rst), .i_if_valid(i_if_valid), .i_if_pc(i_if_pc), .i_if_inst(i_if_inst),
        .o_id_valid(d4_id_valid), .o_id_pc(d4_id_pc), .o_id_inst(d4_id_inst), .o_pc_hold(d4_pc_hold),
        .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata), .i_if_id_halt(i_if_id_halt), .i_id_ex_halt(i_id_ex_halt),
        .i_frwd_alu_op1(i_frwd_alu_op1), .i_frwd_mem_alu_op1(i_frwd_mem_alu_op1), .i_frwd_mem_op1(i_frwd_mem_op1),
        .i_frwd_alu_op2(i_frwd_alu_op2), .i_frwd_mem_alu_op2(i_frwd_mem_alu_op2), .i_frwd_mem_op2(i_frwd_mem_op2),
        .i_ex_alu_res(i_ex_alu_res), .i_mem_alu_res(i_mem_alu_res), .i_mem_rdata(i_mem_rdata), .i_flush(i_flush),
        .o_ex_valid(d4_ex_valid), .o_ex_pc(d4_ex_pc), .o_ex_inst(d4_ex_inst), .o_ex_op1(d4_ex_op1), .o_ex_op2(d4_ex_op2),
        .o_stall_cnt(d4_stall_cnt), .o_flush_cnt(d4_flush_cnt), .o_fwd_err(d4_fwd_err)
    );

    function automatic logic [31:0] pick(logic alu, logic mem_alu, logic mem, logic [31:0] rd);
        if (alu) return i_ex_alu_res;
        if (mem_alu) return i_mem_alu_res;
        if (mem) return i_mem_rdata;
        return rd;
    endfunction

    task automatic idle();
        {i_if_valid, i_if_id_halt, i_id_ex_halt, i_flush} = '0;
        {i_frwd_alu_op1, i_frwd_mem_alu_op1, i_frwd_mem_op1, i_frwd_alu_op2, i_frwd_mem_alu_op2, i_frwd_mem_op2} = '0;
    endtask

    task automatic feed(logic [31:0] pc);
        i_if_valid = 1;
        i_if_pc    = pc;
        i_if_inst  = 32'h0010_0093 + pc;
    endtask

    task automatic tick();
        logic [31:0] o1, o2;
        int n1, n2;
        logic h;
        h  = i_if_id_halt | i_id_ex_halt;
        o1 = pick(i_frwd_alu_op1, i_frwd_mem_alu_op1, i_frwd_mem_op1, i_rs1_rdata);
        o2 = pick(i_frwd_alu_op2, i_frwd_mem_alu_op2, i_frwd_mem_op2, i_rs2_rdata);
        n1 = int'(i_frwd_alu_op1) + int'(i_frwd_mem_alu_op1) + int'(i_frwd_mem_op1);
        n2 = int'(i_frwd_alu_op2) + int'(i_frwd_mem_alu_op2) + int'(i_frwd_mem_op2);
        if (i_rst) begin
            {m_id_v, m_id_pc, m_id_inst} = {1'b0, 32'h0, NOP};
            {m_ex_v, m_ex_pc, m_ex_inst, m_op1, m_op2} = {1'b0, 32'h0, NOP, 64'h0};
            m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0; m_err = 0; m_prev_halt = 0;
        end else begin
            if (!i_flush && (i_if_id_halt != i_id_ex_halt || (m_prev_halt && h) || (m_id_v && (n1 > 1 || n2 > 1))))
                m_err = 1;
            m_prev_halt = h && !i_flush;
            if (i_flush) begin
                m_flush  = (m_flush + 1 > 64'hFFFF_FFFF) ? m_flush : m_flush + 1;
                m_flush4 = (m_flush4 + 1 > 15) ? 15 : m_flush4 + 1;
                {m_id_v, m_id_pc, m_id_inst} = {1'b0, 32'h0, NOP};
                {m_ex_v, m_ex_pc, m_ex_inst, m_op1, m_op2} = {1'b0, 32'h0, NOP, 64'h0};
            end else begin
                if (i_id_ex_halt) {m_ex_v, m_ex_pc, m_ex_inst, m_op1, m_op2} = {1'b0, 32'h0, NOP, 64'h0};
                else {m_ex_v, m_ex_pc, m_ex_inst, m_op1, m_op2} = {m_id_v, m_id_pc, m_id_inst, o1, o2};
                if (i_if_id_halt) begin
                    m_stall  = (m_stall + 1 > 64'hFFFF_FFFF) ? m_stall : m_stall + 1;
                    m_stall4 = (m_stall4 + 1 > 15) ? 15 : m_stall4 + 1;
                end else {m_id_v, m_id_pc, m_id_inst} = {i_if_valid, i_if_pc, i_if_inst};
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        i_rst = 1;
        tick();
        i_rst = 0;
    endtask

    task automatic test_reset();
        idle();
        i_rst = 1;
        i_if_id_halt = 1;
        i_flush = 1;
        tick();
        i_flush = 0;
        #1;
        n_chk++; if (o_pc_hold !== 1'b1) begin n_fail++; $display("FAIL reset_pc_hold: got %b expected 1", o_pc_hold); end
        n_chk++; if ({o_id_valid, o_id_pc, o_id_inst} !== {1'b0, 32'h0, NOP}) begin n_fail++; $display("FAIL reset_id: got %b %h %h expected 0 0 %h", o_id_valid, o_id_pc, o_id_inst, NOP); end
        n_chk++; if ({o_ex_valid, o_ex_pc, o_ex_inst, o_ex_op1, o_ex_op2} !== {1'b0, 32'h0, NOP, 64'h0}) begin n_fail++; $display("FAIL reset_ex: got %b %h %h %h %h", o_ex_valid, o_ex_pc, o_ex_inst, o_ex_op1, o_ex_op2); end
        n_chk++; if ({o_stall_cnt, o_flush_cnt, o_fwd_err} !== 65'h0) begin n_fail++; $display("FAIL reset_cnt: got %h %h %b expected 0 0 0", o_stall_cnt, o_flush_cnt, o_fwd_err); end
        i_rst = 0;
        idle();
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k < 3) feed(32'(4 * k)); else i_if_valid = 0;
            i_rs1_rdata = m_id_pc ^ 32'hA5A5_0000;
            i_rs2_rdata = m_id_pc ^ 32'h0000_5A5A;
            tick();
            if (k >= 1 && k <= 3) begin
                n_chk++; if ({o_ex_valid, o_ex_pc} !== {1'b1, 32'(4 * (k - 1))}) begin n_fail++; $display("FAIL stream_pc%0d: got %b %h expected 1 %h", k, o_ex_valid, o_ex_pc, 4 * (k - 1)); end
                n_chk++; if ({o_ex_op1, o_ex_op2} !== {32'(4 * (k - 1)) ^ 32'hA5A5_0000, 32'(4 * (k - 1)) ^ 32'h0000_5A5A}) begin n_fail++; $display("FAIL stream_ops%0d: got %h %h", k, o_ex_op1, o_ex_op2); end
            end
        end
        idle();
    endtask

    task automatic test_forward();
        do_reset();
        feed(32'h40);
        tick();
        feed(32'h44);
        i_frwd_alu_op1 = 1; i_ex_alu_res = 32'hDEAD_BEEF; i_rs1_rdata = 32'h1; i_rs2_rdata = 32'h2;
        tick();
        n_chk++; if (o_ex_op1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fwd_alu_op1: got %h expected deadbeef", o_ex_op1); end
        n_chk++; if (o_ex_op2 !== 32'h2) begin n_fail++; $display("FAIL fwd_rdata_op2: got %h expected 2", o_ex_op2); end
        i_frwd_alu_op1 = 0;
        feed(32'h48);
        i_frwd_mem_alu_op2 = 1; i_mem_alu_res = 32'hCAFE_0001;
        tick();
        n_chk++; if ({o_ex_op1, o_ex_op2} !== {32'h1, 32'hCAFE_0001}) begin n_fail++; $display("FAIL fwd_mem_alu_op2: got %h %h expected 1 cafe0001", o_ex_op1, o_ex_op2); end
        i_frwd_mem_alu_op2 = 0;
        i_frwd_mem_op2 = 1; i_mem_rdata = 32'h1234_5678;
        tick();
        n_chk++; if ({o_ex_pc, o_ex_op2} !== {32'h48, 32'h1234_5678}) begin n_fail++; $display("FAIL fwd_mem_op2: got %h %h expected 48 12345678", o_ex_pc, o_ex_op2); end
        n_chk++; if (o_fwd_err !== 1'b0) begin n_fail++; $display("FAIL fwd_no_err: got %b expected 0", o_fwd_err); end
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        feed(32'h0); tick();
        feed(32'h4); tick();
        feed(32'h8); tick();
        feed(32'hC);
        i_if_id_halt = 1; i_id_ex_halt = 1;
        #1;
        n_chk++; if (o_pc_hold !== 1'b1) begin n_fail++; $display("FAIL lu_pc_hold: got %b expected 1", o_pc_hold); end
        tick();
        n_chk++; if ({o_ex_valid, o_ex_inst, o_id_pc} !== {1'b0, NOP, 32'h8}) begin n_fail++; $display("FAIL lu_bubble: got %b %h id_pc %h", o_ex_valid, o_ex_inst, o_id_pc); end
        n_chk++; if (o_stall_cnt !== 32'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d expected 1", o_stall_cnt); end
        i_if_id_halt = 0; i_id_ex_halt = 0;
        #1;
        n_chk++; if (o_pc_hold !== 1'b0) begin n_fail++; $display("FAIL lu_pc_release: got %b expected 0", o_pc_hold); end
        tick();
        n_chk++; if ({o_ex_valid, o_ex_pc, o_id_pc, o_fwd_err} !== {1'b1, 32'h8, 32'hC, 1'b0}) begin n_fail++; $display("FAIL lu_resume: got %b %h %h err %b", o_ex_valid, o_ex_pc, o_id_pc, o_fwd_err); end
        idle();
    endtask

    task automatic test_flush_halt();
        feed(32'h10);
        i_flush = 1; i_if_id_halt = 1; i_id_ex_halt = 1;
        #1;
        n_chk++; if (o_pc_hold !== 1'b0) begin n_fail++; $display("FAIL fl_pc_hold: got %b expected 0", o_pc_hold); end
        tick();
        n_chk++; if ({o_id_valid, o_id_inst, o_ex_valid, o_ex_inst} !== {1'b0, NOP, 1'b0, NOP}) begin n_fail++; $display("FAIL fl_bubbles: got %b %h %b %h", o_id_valid, o_id_inst, o_ex_valid, o_ex_inst); end
        n_chk++; if ({o_flush_cnt, o_stall_cnt, o_fwd_err} !== {32'd1, 32'd1, 1'b0}) begin n_fail++; $display("FAIL fl_counts: got flush %0d stall %0d err %b expected 1 1 0", o_flush_cnt, o_stall_cnt, o_fwd_err); end
        idle();
    endtask

    task automatic test_err_mismatch();
        do_reset();
        i_if_id_halt = 1;
        tick();
        i_if_id_halt = 0;
        n_chk++; if (o_fwd_err !== 1'b1) begin n_fail++; $display("FAIL err_mismatch: got %b expected 1", o_fwd_err); end
        tick(); tick(); tick();
        n_chk++; if (o_fwd_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", o_fwd_err); end
        do_reset();
        n_chk++; if (o_fwd_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", o_fwd_err); end
    endtask

    task automatic test_err_multi();
        do_reset();
        i_frwd_alu_op1 = 1; i_frwd_mem_op1 = 1;
        tick();
        n_chk++; if (o_fwd_err !== 1'b0) begin n_fail++; $display("FAIL err_dontcare: got %b expected 0", o_fwd_err); end
        idle();
        feed(32'h80);
        tick();
        i_if_valid = 0;
        i_frwd_alu_op1 = 1; i_frwd_mem_op1 = 1; i_ex_alu_res = 32'h1111; i_mem_rdata = 32'h2222;
        tick();
        n_chk++; if ({o_ex_op1, o_fwd_err} !== {32'h1111, 1'b1}) begin n_fail++; $display("FAIL err_multi: got %h err %b expected 1111 1", o_ex_op1, o_fwd_err); end
        do_reset();
        i_if_id_halt = 1; i_id_ex_halt = 1;
        tick(); tick();
        idle();
        n_chk++; if (o_fwd_err !== 1'b1) begin n_fail++; $display("FAIL err_double_halt: got %b expected 1", o_fwd_err); end
    endtask

    task automatic test_saturate();
        do_reset();
        i_if_id_halt = 1; i_id_ex_halt = 1;
        for (int k = 0; k < 17; k++) tick();
        idle();
        n_chk++; if ({d4_stall_cnt, o_stall_cnt} !== {4'hF, 32'd17}) begin n_fail++; $display("FAIL sat_stall: got %h %0d expected f 17", d4_stall_cnt, o_stall_cnt); end
        i_flush = 1;
        for (int k = 0; k < 17; k++) tick();
        idle();
        n_chk++; if ({d4_flush_cnt, o_flush_cnt, d4_stall_cnt} !== {4'hF, 32'd17, 4'hF}) begin n_fail++; $display("FAIL sat_flush: got %h %0d stall %h expected f 17 f", d4_flush_cnt, o_flush_cnt, d4_stall_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            i_rst = ($urandom_range(59) == 0);
            i_flush = ($urandom_range(7) == 0);
            i_if_id_halt = ($urandom_range(5) == 0);
            i_id_ex_halt = ($urandom_range(49) == 0) ? ~i_if_id_halt : i_if_id_halt;
            i_if_valid = $urandom_range(1); i_if_pc = $urandom & 32'hFFFF_FFFC; i_if_inst = $urandom;
            i_rs1_rdata = $urandom; i_rs2_rdata = $urandom;
            i_ex_alu_res = $urandom; i_mem_alu_res = $urandom; i_mem_rdata = $urandom;
            i_frwd_alu_op1 = ($urandom_range(3) == 0); i_frwd_mem_alu_op1 = ($urandom_range(3) == 0); i_frwd_mem_op1 = ($urandom_range(3) == 0);
            i_frwd_alu_op2 = ($urandom_range(3) == 0); i_frwd_mem_alu_op2 = ($urandom_range(3) == 0); i_frwd_mem_op2 = ($urandom_range(3) == 0);
            #1;
            n_chk++; if (o_pc_hold !== (i_if_id_halt & ~i_flush)) begin n_fail++; $display("FAIL rnd_pc_hold@%0d: got %b", k, o_pc_hold); end
            tick();
            n_chk++; if ({o_id_valid, o_id_pc, o_id_inst} !== {m_id_v, m_id_pc, m_id_inst}) begin n_fail++; $display("FAIL rnd_id@%0d: got %b %h %h expected %b %h %h", k, o_id_valid, o_id_pc, o_id_inst, m_id_v, m_id_pc, m_id_inst); end
            n_chk++; if ({o_ex_valid, o_ex_pc, o_ex_inst, o_ex_op1, o_ex_op2} !== {m_ex_v, m_ex_pc, m_ex_inst, m_op1, m_op2}) begin n_fail++; $display("FAIL rnd_ex@%0d: got %b %h %h %h %h expected %b %h %h %h %h", k, o_ex_valid, o_ex_pc, o_ex_inst, o_ex_op1, o_ex_op2, m_ex_v, m_ex_pc, m_ex_inst, m_op1, m_op2); end
            n_chk++; if ({o_stall_cnt, o_flush_cnt, d4_stall_cnt, d4_flush_cnt, o_fwd_err} !== {m_stall[31:0], m_flush[31:0], 4'(m_stall4), 4'(m_flush4), m_err}) begin n_fail++; $display("FAIL rnd_cnt@%0d: got %0d %0d %0d %0d %b expected %0d %0d %0d %0d %b", k, o_stall_cnt, o_flush_cnt, d4_stall_cnt, d4_flush_cnt, o_fwd_err, m_stall, m_flush, m_stall4, m_flush4, m_err); end
        end
        i_rst = 0;
        idle();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_forward();
        test_load_use();
        test_flush_halt();
        test_err_mismatch();
        test_err_multi();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
